// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-locking arbiter sharing one FIFO write
// port among NUM_REQ valid/ready requesters. A grant is held for a whole
// burst, which ends on req_last or at MAX_BURST beats. Priority then rotates.
//
// Handshake: a beat moves on any cycle where valid and ready are both high.
// This holds for each requester (req_val/req_rdy) and for the FIFO side
// (out_val/out_rdy). Ready never depends on the valid of the same channel.
// Valid may drop at any time, and the grant is kept while it is low.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 16,
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CW = $clog2(MAX_BURST + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_val,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic [NUM_REQ-1:0]       req_rdy,
    output logic                     out_val,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_last,
    input  logic                     out_rdy,
    output logic                     grant_val,
    output logic [IW-1:0]            grant_idx,
    output logic                     burst_trunc,
    output logic                     dbg_state,
    output logic [CW-1:0]            dbg_beat_cnt
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [CW-1:0] CAP = CW'(MAX_BURST - 1);

    state_t        state;
    logic [IW-1:0] last_grant;
    logic [CW-1:0] beat_cnt;

    logic          busy;
    logic          win_found;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] cand;
    logic          xfer;

    // The grant is suppressed during reset, so no beat is accepted then.
    assign busy = (state == BUSY) && !rst;

    // Round-robin scan starting just after the previous grantee.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((int'(last_grant) + k) % NUM_REQ);
            if (!win_found && req_val[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Combinational data path from the granted requester to the FIFO port.
    always_comb begin
        out_data    = req_data[int'(grant_idx)*WIDTH +: WIDTH];
        out_val     = busy && req_val[grant_idx];
        out_last    = busy && (req_last[grant_idx] || (beat_cnt == CAP));
        grant_val   = busy;
        xfer        = out_val && out_rdy;
        burst_trunc = xfer && out_last && !req_last[grant_idx];
        for (int i = 0; i < NUM_REQ; i++) begin
            req_rdy[i] = busy && out_rdy && (grant_idx == IW'(i));
        end
    end

    assign dbg_state    = (state == BUSY);
    assign dbg_beat_cnt = beat_cnt;

    // Grant FSM: arbitrate in IDLE, then count beats in BUSY until the burst ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= IW'(NUM_REQ - 1);
            grant_idx  <= '0;
            beat_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        grant_idx <= win_idx;
                        beat_cnt  <= '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (xfer) begin
                        if (out_last) begin
                            last_grant <= grant_idx;
                            beat_cnt   <= '0;
                            state      <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin, burst-locking arbiter that shares the single write (input) port of a `fifo` instance among `NUM_REQ` valid/ready requesters. It sits between the requester channels and the FIFO's `data_in`/`inp_val`/`inp_rdy` port. It grants one requester at a time for a whole burst, delimited by `last` or by a `MAX_BURST` cap, then rotates priority.

## Interface
- `NUM_REQ`, default 4: number of requesters; must be ≥ 2.
- `WIDTH`, default 8: data width; must match the FIFO `WIDTH`.
- `MAX_BURST`, default 16: maximum beats per grant; must be ≥ 1.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_val`  in  NUM_REQ  per-requester valid.
- `req_data`  in  NUM_REQ*WIDTH  requester i occupies bits `[i*WIDTH +: WIDTH]`.
- `req_last`  in  NUM_REQ  per-requester end-of-burst flag, qualified by `req_val`.
- `req_rdy`  out  NUM_REQ  per-requester ready; at most one bit is set.
- `out_val`  out  1  to FIFO `inp_val`.
- `out_data`  out  WIDTH  to FIFO `data_in`.
- `out_last`  out  1  end-of-burst, as forwarded or forced.
- `out_rdy`  in  1  from FIFO `inp_rdy`.
- `grant_val`  out  1  high while a grant is held.
- `grant_idx`  out  $clog2(NUM_REQ)  current or most recent grantee.
- `burst_trunc`  out  1  one-cycle pulse when a burst is cut at `MAX_BURST`.

## Operation
**States**
- The FSM has two states: IDLE and BUSY.
- Registers: `grant_idx`, `last_grant` (width $clog2(NUM_REQ)), and `beat_cnt` (width $clog2(MAX_BURST+1)).

**IDLE**
- `out_val`, `req_rdy`, and `grant_val` are 0.
- If any `req_val` bit is set, the winner is the first set bit scanning `last_grant+1`, `last_grant+2`, … modulo `NUM_REQ`.
- On a win: `grant_idx` is loaded with the winner, `beat_cnt` is cleared to 0, and the FSM moves to BUSY.
- If no `req_val` bit is set, the FSM stays in IDLE.
- `req_last` is ignored in IDLE.

**BUSY**
- `grant_val` = 1.
- `out_val = req_val[grant_idx]`, `out_data = req_data[grant_idx]`.
- `out_last = req_last[grant_idx] | (beat_cnt == MAX_BURST-1)`.
- `req_rdy[grant_idx] = out_rdy`; all other `req_rdy` bits are 0.
- A transfer occurs when `out_val & out_rdy`.
- On a transfer with `out_last` = 0: `beat_cnt` increments.
- On a transfer with `out_last` = 1: `last_grant` ← `grant_idx`, the FSM returns to IDLE, and `beat_cnt` clears.
- If the transfer ends the burst with `req_last[grant_idx]` = 0 (i.e. the cap was hit), `burst_trunc` pulses for that same cycle (combinational with the transfer).
- The grantee dropping `req_val` mid-burst has no effect on the grant: the grant is held, `out_val` is 0, and the arbiter waits indefinitely. There is no timeout.
- Other requesters' `req_val` changes have no effect while in BUSY.

**Boundary conditions**
- FIFO full (`out_rdy` = 0): no transfer, all state holds, and `req_rdy[grant_idx]` = 0.
- `MAX_BURST` = 1: every beat ends the burst.
- Single active requester: it is re-granted after each burst, with one idle cycle between bursts.
- Priority wrap-around: after the grant to `NUM_REQ-1`, the scan starts at index 0.

## Timing
**Reset**
- Effective on the cycle `rst` is sampled high: state → IDLE, `last_grant` → `NUM_REQ-1` (so requester 0 has top priority first), `grant_idx` → 0, `beat_cnt` → 0.
- Output values during and after reset: `out_val` 0, `req_rdy` all 0, `grant_val` 0, `burst_trunc` 0, `out_last` 0.
- Reset mid-burst: no transfer is accepted in the reset cycle (`req_rdy` is forced to 0). The interrupted burst is abandoned and not resumed.

**Latency**
- Arbitration costs exactly one cycle: a request seen in IDLE at cycle t can transfer its first beat at the earliest at cycle t+1.
- Beats within a burst transfer back-to-back, one per cycle, while valid and ready are both high.
- Data path is combinational from `req_*[grant_idx]` to `out_*`; `grant_idx` itself is a register.
- Maximum sustained throughput is B/(B+1) beats per cycle for bursts of B beats.

## Test plan
- Reset, then `req_val` = 4'b0000 for 5 cycles → `out_val` = 0, `grant_val` = 0, `req_rdy` = 0 throughout.
- `req_val` = 4'b1111, each requester sending 2-beat bursts (last on beat 2), `out_rdy` = 1 → grant order 0, 1, 2, 3, 0. Each burst has a 1-cycle gap before it, and `out_data` carries the matching requester's data.
- Requester 2 alone sends a 20-beat stream with `req_last` never set, `MAX_BURST` = 16 → `out_last` and `burst_trunc` = 1 on beat 16, FSM returns to IDLE, requester 2 is re-granted, and the remaining 4 beats transfer.
- Grant to requester 1 mid-burst, then `out_rdy` = 0 for 3 cycles → `req_rdy[1]` = 0, `beat_cnt` and `out_data` stable, no extra beats enter the FIFO, and the burst resumes when `out_rdy` = 1.
- Requester 3 deasserts `req_val` for 2 cycles mid-burst while requester 0 is requesting → the grant stays on 3, `out_val` = 0 for those 2 cycles, and requester 0 is granted only after 3's last beat.
- Assert `rst` for 1 cycle during beat 3 of a 5-beat burst → no transfer in the reset cycle, IDLE the next cycle, and the first grant after reset goes to the lowest-index requester whose `req_val` is set.
